// File: rtl/alu_logic_pkg.sv
// rtl/alu_logic_pkg.sv - shared opcode encoding and default width for the logic unit
package alu_logic_pkg;

    // Default operand/result width
    localparam int ALU_LOGIC_WIDTH = 8;

    // Logic opcodes; the 2-bit field is fully decoded
    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NOTA = 2'd3
    } alu_logic_op_e;

    // Odd parity of a result word (1 when the number of set bits is odd)
    function automatic logic odd_parity(input logic [ALU_LOGIC_WIDTH-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/alu_logic_core.sv
// rtl/alu_logic_core.sv - combinational bitwise logic op with zero and parity flags
import alu_logic_pkg::*;

module alu_logic_core #(
    parameter int WIDTH = ALU_LOGIC_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_logic_op_e    op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity
);

    // Select the bitwise operation; b is not used for NOT A
    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOTA: result = ~a;
            default: result = '0;
        endcase
    end

    // Flags derive from the same result word so they never disagree with it
    always_comb begin
        zero   = (result == '0);
        parity = ^result;
    end

endmodule

// File: rtl/alu_logic.sv
// rtl/alu_logic.sv - registered logic unit with valid strobe, zero and parity flags
import alu_logic_pkg::*;

module alu_logic #(
    parameter int WIDTH = ALU_LOGIC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             zero,
    output logic             parity
);

    logic [WIDTH-1:0] core_result;
    logic             core_zero;
    logic             core_parity;

    alu_logic_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (a),
        .b      (b),
        .op     (alu_logic_op_e'(s)),
        .result (core_result),
        .zero   (core_zero),
        .parity (core_parity)
    );

    // Result and flags load only on an accepted request, otherwise hold;
    // idle-cycle operand values (even X/Z) never reach the registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out    <= '0;
            zero   <= 1'b0;
            parity <= 1'b0;
        end else if (in_valid) begin
            out    <= core_result;
            zero   <= core_zero;
            parity <= core_parity;
        end
    end

    // One-cycle valid per accepted request; reset drops it immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_alu_logic.sv
// tb/tb_alu_logic.sv - scoreboard bench for the registered logic unit
module tb_alu_logic;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a        = 8'h00;
    logic [7:0] b        = 8'h00;
    logic [1:0] s        = 2'd0;
    logic [7:0] out;
    logic       out_valid;
    logic       zero;
    logic       parity;

    int n_checks = 0;
    int n_fail   = 0;

    // expected {out, zero, parity}
    logic [9:0] sb[$];

    alu_logic #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .s         (s),
        .out       (out),
        .out_valid (out_valid),
        .zero      (zero),
        .parity    (parity)
    );

    always #5 clk = ~clk;

    // Drive one request on the falling edge and record its expected result
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] is_,
                         input logic [7:0] eo, input logic ez, input logic ep);
        @(negedge clk);
        in_valid = 1'b1;
        a = ia;
        b = ib;
        s = is_;
        sb.push_back({eo, ez, ep});
    endtask

    // Idle cycle with random operands that must be ignored
    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        s = 2'($urandom);
    endtask

    // Outputs must be at their reset values
    task automatic check_reset_state(input string name);
        n_checks++;
        if (out !== 8'h00 || out_valid !== 1'b0 || zero !== 1'b0 || parity !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got out=%h out_valid=%b zero=%b parity=%b, required 00 0 0 0",
                     name, out, out_valid, zero, parity);
        end
    endtask

    // Monitor: pop and compare on every valid result, check hold otherwise
    initial begin : monitor
        logic [9:0] e;
        logic [9:0] last;
        last = 10'h000;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                last = 10'h000;
            end else if (out_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid: out_valid=1 out=%h with no request pending, required out_valid=0", out);
                end else begin
                    e = sb.pop_front();
                    if ({out, zero, parity} !== e) begin
                        n_fail++;
                        $display("FAIL result: got out=%h zero=%b parity=%b, required out=%h zero=%b parity=%b",
                                 out, zero, parity, e[9:2], e[1], e[0]);
                    end
                end
                last = {out, zero, parity};
            end else begin
                n_checks++;
                if ({out, zero, parity} !== last) begin
                    n_fail++;
                    $display("FAIL hold: got out=%h zero=%b parity=%b, required held out=%h zero=%b parity=%b",
                             out, zero, parity, last[9:2], last[1], last[0]);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // Asynchronous reset with no clock edge
        #1 rst = 1'b1;
        #1 check_reset_state("reset_async");
        repeat (2) @(negedge clk);
        check_reset_state("reset_held");
        rst = 1'b0;

        // AND
        issue(8'h00, 8'h00, 2'd0, 8'h00, 1'b1, 1'b0);
        issue(8'h00, 8'h01, 2'd0, 8'h00, 1'b1, 1'b0);
        issue(8'h01, 8'h00, 2'd0, 8'h00, 1'b1, 1'b0);
        issue(8'h01, 8'h01, 2'd0, 8'h01, 1'b0, 1'b1);
        issue(8'hF0, 8'h3C, 2'd0, 8'h30, 1'b0, 1'b0);
        // OR
        issue(8'h00, 8'h00, 2'd1, 8'h00, 1'b1, 1'b0);
        issue(8'h00, 8'h01, 2'd1, 8'h01, 1'b0, 1'b1);
        issue(8'h01, 8'h00, 2'd1, 8'h01, 1'b0, 1'b1);
        issue(8'h01, 8'h01, 2'd1, 8'h01, 1'b0, 1'b1);
        issue(8'hAA, 8'h55, 2'd1, 8'hFF, 1'b0, 1'b0);
        // XOR
        issue(8'h00, 8'h00, 2'd2, 8'h00, 1'b1, 1'b0);
        issue(8'h00, 8'h01, 2'd2, 8'h01, 1'b0, 1'b1);
        issue(8'h01, 8'h00, 2'd2, 8'h01, 1'b0, 1'b1);
        issue(8'h01, 8'h01, 2'd2, 8'h00, 1'b1, 1'b0);
        issue(8'hAA, 8'h55, 2'd2, 8'hFF, 1'b0, 1'b0);
        // NOT A; b must not matter
        issue(8'h00, 8'h00, 2'd3, 8'hFF, 1'b0, 1'b0);
        issue(8'h01, 8'hFF, 2'd3, 8'hFE, 1'b0, 1'b1);
        issue(8'h01, 8'h00, 2'd3, 8'hFE, 1'b0, 1'b1);

        // Single pulse then three idle cycles with random operands
        idle();
        issue(8'h12, 8'h34, 2'd2, 8'h26, 1'b0, 1'b1);
        repeat (3) idle();

        // Four back-to-back requests
        issue(8'h12, 8'h34, 2'd2, 8'h26, 1'b0, 1'b1);
        issue(8'h0F, 8'hF0, 2'd1, 8'hFF, 1'b0, 1'b0);
        issue(8'hC3, 8'h81, 2'd0, 8'h81, 1'b0, 1'b0);
        issue(8'h5A, 8'h77, 2'd3, 8'hA5, 1'b0, 1'b0);
        repeat (2) idle();

        // Mid-stream reset during the third request
        issue(8'hFF, 8'h0F, 2'd0, 8'h0F, 1'b0, 1'b0);
        issue(8'h80, 8'h00, 2'd1, 8'h80, 1'b0, 1'b1);
        @(negedge clk);
        a = 8'h33;
        b = 8'h0F;
        s = 2'd1;
        #1 rst = 1'b1;
        #1 check_reset_state("reset_midstream");
        @(negedge clk);
        check_reset_state("reset_midstream_held");
        rst = 1'b0;
        in_valid = 1'b0;
        issue(8'h3C, 8'hC3, 2'd2, 8'hFF, 1'b0, 1'b0);
        issue(8'h07, 8'h00, 2'd3, 8'hF8, 1'b0, 1'b1);
        repeat (3) idle();

        // Every expected result must have been observed
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results still pending, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
